error_sampler: RTL and testbench

Upstream stage of the PID datapath. It periodically samples setpoint and measurement and computes the saturated signed error e, plus the error delta (derivative term) and running error sum (integral term). All three are held stable for a full sample period so the repeated-add multipliers downstream have constant operands. A one-cycle strobe marks each new sample.

---
 rtl/pid_pkg.sv | 27 ++
 rtl/error_sampler_sat_addsub.sv | 40 ++++
 rtl/error_sampler.sv | 98 +++++++++
 tb/tb_error_sampler.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// Shared definitions for the PID datapath: default operand width, error limits
// and the WIDTH+1 -> WIDTH saturating clamp used by every arithmetic stage.
package pid_pkg;

  localparam int WIDTH = 6;

  localparam logic signed [WIDTH-1:0] ERR_MAX = 6'sd31;
  localparam logic signed [WIDTH-1:0] ERR_MIN = -6'sd32;

  // Limits sign-extended to the intermediate width for comparison.
  localparam logic signed [WIDTH:0] ERR_MAX_W = 7'sd31;
  localparam logic signed [WIDTH:0] ERR_MIN_W = -7'sd32;

  // Clamp a WIDTH+1 bit signed intermediate into the WIDTH-bit result range.
  function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [WIDTH:0] value);
    logic signed [WIDTH-1:0] res;
    if (value > ERR_MAX_W) begin
      res = ERR_MAX;
    end else if (value < ERR_MIN_W) begin
      res = ERR_MIN;
    end else begin
      res = value[WIDTH-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/error_sampler_sat_addsub.sv
// Saturating add/subtract stage. Operands are widened by one bit (sign- or
// zero-extended depending on SIGNED_OPS) so the raw result never wraps, then
// clamped back to WIDTH bits. Purely combinational; the caller registers it.
module sat_addsub #(
  parameter int WIDTH      = pid_pkg::WIDTH,
  parameter bit SIGNED_OPS = 1'b1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] y
);
  import pid_pkg::*;

  logic signed [WIDTH:0] a_ext_s;
  logic signed [WIDTH:0] b_ext_s;
  logic signed [WIDTH:0] raw_s;

  // Widen operands, apply the selected operation and clamp.
  always_comb begin
    a_ext_s = '0;
    b_ext_s = '0;
    raw_s   = '0;
    y       = '0;
    if (SIGNED_OPS) begin
      a_ext_s = {a[WIDTH-1], a};
      b_ext_s = {b[WIDTH-1], b};
    end else begin
      a_ext_s = {1'b0, a};
      b_ext_s = {1'b0, b};
    end
    if (sub) begin
      raw_s = a_ext_s - b_ext_s;
    end else begin
      raw_s = a_ext_s + b_ext_s;
    end
    y = sat_w(raw_s);
  end

endmodule

// File: rtl/error_sampler.sv
// Periodic error sampler feeding the PID multipliers. Every SAMPLE_DIV enabled
// cycles it captures setpoint/measurement, and registers the saturated error,
// its delta against the previous sample and the anti-windup error sum. All
// three stay constant for a full period; sample_stb flags each new set.
module error_sampler #(
  parameter int WIDTH      = pid_pkg::WIDTH,
  parameter int SAMPLE_DIV = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] setpoint,
  input  logic [WIDTH-1:0] measurement,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] e_delta,
  output logic [WIDTH-1:0] e_sum,
  output logic             sample_stb
);
  import pid_pkg::*;

  localparam int                CNT_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] e_r;
  logic [WIDTH-1:0] e_delta_r;
  logic [WIDTH-1:0] e_sum_r;
  logic             stb_r;

  logic             tick_s;
  logic [WIDTH-1:0] e_new_s;
  logic [WIDTH-1:0] delta_new_s;
  logic [WIDTH-1:0] sum_new_s;

  // Sample instant: last count of the period while enabled.
  always_comb begin
    tick_s = 1'b0;
    if (ena && (cnt_r == CNT_LAST)) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
  end

  // setpoint - measurement on unsigned inputs, clamped to the signed range.
  sat_addsub #(.WIDTH(WIDTH), .SIGNED_OPS(1'b0)) u_err (
    .a   (setpoint),
    .b   (measurement),
    .sub (1'b1),
    .y   (e_new_s)
  );

  // New (already saturated) error minus the currently held error.
  sat_addsub #(.WIDTH(WIDTH), .SIGNED_OPS(1'b1)) u_delta (
    .a   (e_new_s),
    .b   (e_r),
    .sub (1'b1),
    .y   (delta_new_s)
  );

  // Running sum with clamping, so it parks at a limit instead of winding up.
  sat_addsub #(.WIDTH(WIDTH), .SIGNED_OPS(1'b1)) u_sum (
    .a   (e_sum_r),
    .b   (e_new_s),
    .sub (1'b0),
    .y   (sum_new_s)
  );

  // Divider counter, output registers and strobe; reset wins over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r     <= '0;
      e_r       <= '0;
      e_delta_r <= '0;
      e_sum_r   <= '0;
      stb_r     <= 1'b0;
    end else if (ena) begin
      stb_r <= tick_s;
      if (tick_s) begin
        cnt_r     <= '0;
        e_r       <= e_new_s;
        e_delta_r <= delta_new_s;
        e_sum_r   <= sum_new_s;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end else begin
      stb_r <= 1'b0;
    end
  end

  assign e          = e_r;
  assign e_delta    = e_delta_r;
  assign e_sum      = e_sum_r;
  assign sample_stb = stb_r;

endmodule

// File: tb/tb_error_sampler.sv
// Directed bench for error_sampler with SAMPLE_DIV=4, WIDTH=6.
module tb_error_sampler;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [5:0] setpoint;
  logic [5:0] measurement;
  logic [5:0] e;
  logic [5:0] e_delta;
  logic [5:0] e_sum;
  logic       sample_stb;

  int compared   = 0;
  int mismatched = 0;

  // Last expected output set, used to confirm values hold between ticks.
  logic [5:0] held_e, held_d, held_s;

  error_sampler #(.WIDTH(6), .SAMPLE_DIV(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .setpoint    (setpoint),
    .measurement (measurement),
    .e           (e),
    .e_delta     (e_delta),
    .e_sum       (e_sum),
    .sample_stb  (sample_stb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [5:0] observed, input logic [5:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Quiet cycle: no strobe, outputs unchanged.
  task automatic quiet(input string tag);
    step();
    check({tag, "_stb"}, {5'b0, sample_stb}, 6'h00);
    check({tag, "_e"}, e, held_e);
    check({tag, "_s"}, e_sum, held_s);
  endtask

  // Tick cycle: strobe plus the new expected values.
  task automatic tick(input string tag, input logic [5:0] xe, input logic [5:0] xd, input logic [5:0] xs);
    step();
    check({tag, "_stb"}, {5'b0, sample_stb}, 6'h01);
    check({tag, "_e"}, e, xe);
    check({tag, "_d"}, e_delta, xd);
    check({tag, "_s"}, e_sum, xs);
    held_e = xe;
    held_d = xd;
    held_s = xs;
  endtask

  // Full period: three quiet edges followed by the tick edge.
  task automatic period(input string tag, input logic [5:0] xe, input logic [5:0] xd, input logic [5:0] xs);
    quiet({tag, "_q1"});
    quiet({tag, "_q2"});
    quiet({tag, "_q3"});
    tick(tag, xe, xd, xs);
  endtask

  initial begin
    rst = 1'b1;
    ena = 1'b1;
    setpoint = 6'd40;
    measurement = 6'd10;
    held_e = 6'h00;
    held_d = 6'h00;
    held_s = 6'h00;

    // Reset held for three edges.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_stb", {5'b0, sample_stb}, 6'h00);
      check("rst_e", e, 6'h00);
      check("rst_d", e_delta, 6'h00);
      check("rst_s", e_sum, 6'h00);
    end
    rst = 1'b0;

    // 40-10=30; first strobe on 4th edge after release.
    period("p1", 6'h1E, 6'h1E, 6'h1E);
    period("p2", 6'h1E, 6'h00, 6'h1F);      // 30+30 clamps to 31
    period("p3", 6'h1E, 6'h00, 6'h1F);      // sum holds at upper limit
    check("p3_d_held", e_delta, 6'h00);

    setpoint = 6'd63; measurement = 6'd0;
    period("p4", 6'h1F, 6'h01, 6'h1F);      // e=31, delta 1

    setpoint = 6'd0; measurement = 6'd63;
    period("p5", 6'h20, 6'h20, 6'h3F);      // e=-32, delta -63->-32, sum -1
    period("p6", 6'h20, 6'h00, 6'h20);      // sum -33 clamps to -32
    period("p7", 6'h20, 6'h00, 6'h20);      // sum holds at lower limit

    setpoint = 6'd40; measurement = 6'd10;
    period("p8", 6'h1E, 6'h1F, 6'h3E);      // delta 62->31, sum -2 off limit

    // Enable gap at cnt=2; inputs wiggled during the gap must not matter.
    quiet("g_c1");
    quiet("g_c2");
    ena = 1'b0;
    setpoint = 6'd0; measurement = 6'd63;
    for (int i = 0; i < 10; i++) begin
      quiet("gap");
      check("gap_d", e_delta, held_d);
    end
    ena = 1'b1;
    setpoint = 6'd20; measurement = 6'd10;
    quiet("g_c3");
    tick("g_tick", 6'h0A, 6'h2C, 6'h08);     // e=10, delta -20, sum 8
    quiet("g_after");

    // Reset asserted on a tick edge with nonzero inputs.
    quiet("r_c2");
    quiet("r_c3");
    setpoint = 6'd63; measurement = 6'd0;
    rst = 1'b1;
    step();
    check("rtick_stb", {5'b0, sample_stb}, 6'h00);
    check("rtick_e", e, 6'h00);
    check("rtick_d", e_delta, 6'h00);
    check("rtick_s", e_sum, 6'h00);
    rst = 1'b0;
    held_e = 6'h00;
    held_d = 6'h00;
    held_s = 6'h00;
    period("post_rst", 6'h1F, 6'h1F, 6'h1F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
